// File: rtl/pulse_pattern_gen_if.sv
// Host write bus for pulse_pattern_gen: 3-bit halfword address, write strobe, 16-bit data.
interface pulse_pattern_gen_if;
    logic [2:0]  ADDR;
    logic        WR_EN;
    logic [15:0] DATA;

    modport master (output ADDR, output WR_EN, output DATA);
    modport slave  (input  ADDR, input  WR_EN, input  DATA);
endinterface

// File: rtl/pulse_pattern_gen.sv
// Programmable rectangular pulse generator with host-written high/low times.
// Define PULSE_GEN_BURST_EN for finite bursts with a sticky completion irq.
module pulse_pattern_gen #(
    parameter logic [31:0] DEF_HIGH = 32'd50,
    parameter logic [31:0] DEF_LOW  = 32'd50
) (
    input  logic                clk_base,
    input  logic                rst_n,
    pulse_pattern_gen_if.slave  host,
    output logic                pulse_out,
    output logic                period_done,
    output logic                busy,
    output logic                irq
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [2:0] A_HIGH_L  = 3'd0;
    localparam logic [2:0] A_HIGH_H  = 3'd1;
    localparam logic [2:0] A_LOW_L   = 3'd2;
    localparam logic [2:0] A_LOW_H   = 3'd3;
    localparam logic [2:0] A_CTRL    = 3'd4;
    localparam logic [2:0] A_BURST   = 3'd5;
    localparam logic [2:0] A_IRQ_CLR = 3'd6;

    state_t      state;
    logic        run, inv;
    logic [31:0] pending_high, pending_low;
    logic [31:0] active_high, active_low;
    logic [31:0] counter;

    // A zero duration would never match the counter; clamp to one cycle.
    function automatic logic [31:0] nz(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

`ifdef PULSE_GEN_BURST_EN
    logic [15:0] burst_n, remaining;
`else
    assign irq = 1'b0;
`endif

    always_ff @(posedge clk_base) begin
        if (!rst_n) begin
            state        <= IDLE;
            pulse_out    <= 1'b0;
            period_done  <= 1'b0;
            busy         <= 1'b0;
            run          <= 1'b0;
            inv          <= 1'b0;
            pending_high <= DEF_HIGH;
            pending_low  <= DEF_LOW;
            active_high  <= DEF_HIGH;
            active_low   <= DEF_LOW;
            counter      <= 32'd0;
`ifdef PULSE_GEN_BURST_EN
            irq          <= 1'b0;
            burst_n      <= 16'd0;
            remaining    <= 16'd0;
`endif
        end else begin
            period_done <= 1'b0;
            pulse_out   <= (state == HIGH) ? ~inv : inv;
            busy        <= (state != IDLE);

            if (host.WR_EN) begin
                case (host.ADDR)
                    A_HIGH_L:  pending_high[15:0]  <= host.DATA;
                    A_HIGH_H:  pending_high[31:16] <= host.DATA;
                    A_LOW_L:   pending_low[15:0]   <= host.DATA;
                    A_LOW_H:   pending_low[31:16]  <= host.DATA;
                    A_CTRL: begin
                        run <= host.DATA[0];
                        inv <= host.DATA[1];
                    end
`ifdef PULSE_GEN_BURST_EN
                    A_BURST:   burst_n <= host.DATA;
                    A_IRQ_CLR: irq     <= 1'b0;
`endif
                    default: ;
                endcase
            end

            // LOAD reads pending through non-blocking semantics, so a write
            // landing on the same edge only affects the next period.
            case (state)
                IDLE: begin
                    if (run) begin
                        active_high <= nz(pending_high);
                        active_low  <= nz(pending_low);
                        counter     <= 32'd1;
                        state       <= HIGH;
`ifdef PULSE_GEN_BURST_EN
                        remaining   <= burst_n;
`endif
                    end
                end
                HIGH: begin
                    if (counter == active_high) begin
                        state   <= LOW;
                        counter <= 32'd1;
                    end else begin
                        counter <= counter + 32'd1;
                    end
                end
                LOW: begin
                    if (counter == active_low) begin
                        period_done <= 1'b1;
                        counter     <= 32'd1;
`ifdef PULSE_GEN_BURST_EN
                        // Burst end overrides any same-cycle run write or irq clear.
                        if (remaining == 16'd1) begin
                            remaining <= 16'd0;
                            run       <= 1'b0;
                            irq       <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            if (remaining != 16'd0)
                                remaining <= remaining - 16'd1;
                            if (run) begin
                                active_high <= nz(pending_high);
                                active_low  <= nz(pending_low);
                                state       <= HIGH;
                            end else begin
                                state <= IDLE;
                            end
                        end
`else
                        if (run) begin
                            active_high <= nz(pending_high);
                            active_low  <= nz(pending_low);
                            state       <= HIGH;
                        end else begin
                            state <= IDLE;
                        end
`endif
                    end else begin
                        counter <= counter + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_pattern_gen.sv
// Directed bench for pulse_pattern_gen; outputs sampled 1ns after each rising edge.
module tb_pulse_pattern_gen;

    logic clk_base = 1'b0;
    logic rst_n    = 1'b0;
    logic pulse_out, period_done, busy, irq;
    int   errors = 0;
    int   checks = 0;

    pulse_pattern_gen_if host_if ();

    pulse_pattern_gen #(.DEF_HIGH(32'd50), .DEF_LOW(32'd50)) dut (
        .clk_base    (clk_base),
        .rst_n       (rst_n),
        .host        (host_if.slave),
        .pulse_out   (pulse_out),
        .period_done (period_done),
        .busy        (busy),
        .irq         (irq)
    );

    always #5 clk_base = ~clk_base;

    task automatic tick();
        @(posedge clk_base);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        host_if.ADDR  = a;
        host_if.DATA  = d;
        host_if.WR_EN = 1'b1;
        tick();
        host_if.WR_EN = 1'b0;
    endtask

    task automatic do_reset();
        host_if.WR_EN = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // n observed cycles at level lvl; period_done expected only on the last if done_last
    task automatic seg(input string tag, input logic lvl, input int n, input logic done_last);
        for (int i = 0; i < n; i++) begin
            tick();
            chk({tag, "_pulse"}, {31'd0, pulse_out}, {31'd0, lvl});
            chk({tag, "_pdone"}, {31'd0, period_done}, {31'd0, done_last && (i == n - 1)});
        end
    endtask

    initial begin
        host_if.ADDR  = 3'd0;
        host_if.DATA  = 16'd0;
        host_if.WR_EN = 1'b0;

        // reset state
        do_reset();
        chk("rst_pulse", {31'd0, pulse_out},   32'd0);
        chk("rst_pdone", {31'd0, period_done}, 32'd0);
        chk("rst_busy",  {31'd0, busy},        32'd0);
        chk("rst_irq",   {31'd0, irq},         32'd0);

        // 3 high / 5 low, continuous
        wr(3'd0, 16'd3);
        wr(3'd2, 16'd5);
        wr(3'd4, 16'd1);
        tick();
        chk("p35_pre", {31'd0, pulse_out}, 32'd0);
        seg("p35_h1", 1'b1, 3, 1'b0);
        chk("p35_busy", {31'd0, busy}, 32'd1);
        seg("p35_l1", 1'b0, 5, 1'b1);
        seg("p35_h2", 1'b1, 3, 1'b0);
        seg("p35_l2", 1'b0, 5, 1'b1);
        chk("p35_busy2", {31'd0, busy}, 32'd1);

        // zero durations clamp to one cycle
        do_reset();
        wr(3'd0, 16'd0);
        wr(3'd2, 16'd0);
        wr(3'd4, 16'd1);
        tick();
        for (int p = 0; p < 3; p++) begin
            seg("z_h", 1'b1, 1, 1'b0);
            seg("z_l", 1'b0, 1, 1'b1);
        end

        // mid-period HIGH write affects only the next period
        do_reset();
        wr(3'd0, 16'd4);
        wr(3'd2, 16'd4);
        wr(3'd4, 16'd1);
        tick();
        seg("m_h1", 1'b1, 1, 1'b0);
        wr(3'd0, 16'd10);
        chk("m_h2", {31'd0, pulse_out}, 32'd1);
        seg("m_h34", 1'b1, 2, 1'b0);
        seg("m_l", 1'b0, 4, 1'b1);
        seg("m_h10", 1'b1, 10, 1'b0);
        seg("m_l2", 1'b0, 4, 1'b1);

        // run cleared mid-period: period completes, then idle
        do_reset();
        wr(3'd0, 16'd4);
        wr(3'd2, 16'd4);
        wr(3'd4, 16'd1);
        tick();
        seg("s_h1", 1'b1, 1, 1'b0);
        wr(3'd4, 16'd0);
        chk("s_h2", {31'd0, pulse_out}, 32'd1);
        seg("s_h34", 1'b1, 2, 1'b0);
        seg("s_l", 1'b0, 4, 1'b1);
        chk("s_busy_last", {31'd0, busy}, 32'd1);
        seg("s_idle", 1'b0, 4, 1'b0);
        chk("s_busy_idle", {31'd0, busy}, 32'd0);

        // defaults, inverted, then inv cleared mid-run
        do_reset();
        wr(3'd4, 16'd3);
        tick();
        chk("i_pre", {31'd0, pulse_out}, 32'd1);
        seg("i_h", 1'b0, 50, 1'b0);
        seg("i_l", 1'b1, 50, 1'b1);
        seg("i_h2", 1'b0, 3, 1'b0);
        wr(3'd4, 16'd1);
        chk("i_flip0", {31'd0, pulse_out}, 32'd0);
        tick();
        chk("i_flip1", {31'd0, pulse_out}, 32'd1);

`ifdef PULSE_GEN_BURST_EN
        // burst of 2 periods, irq sticky until cleared
        do_reset();
        wr(3'd5, 16'd2);
        wr(3'd0, 16'd2);
        wr(3'd2, 16'd2);
        wr(3'd4, 16'd1);
        tick();
        seg("b_h1", 1'b1, 2, 1'b0);
        seg("b_l1", 1'b0, 2, 1'b1);
        chk("b_irq_mid", {31'd0, irq}, 32'd0);
        seg("b_h2", 1'b1, 2, 1'b0);
        seg("b_l2", 1'b0, 2, 1'b1);
        chk("b_irq_set", {31'd0, irq}, 32'd1);
        seg("b_idle", 1'b0, 4, 1'b0);
        chk("b_busy", {31'd0, busy}, 32'd0);
        chk("b_irq_hold", {31'd0, irq}, 32'd1);
        wr(3'd6, 16'd0);
        chk("b_irq_clr", {31'd0, irq}, 32'd0);

        // reset mid-burst
        wr(3'd5, 16'd5);
        wr(3'd4, 16'd1);
        tick();
        seg("r_h", 1'b1, 2, 1'b0);
        chk("r_busy_pre", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        chk("r_pulse", {31'd0, pulse_out},   32'd0);
        chk("r_busy",  {31'd0, busy},        32'd0);
        chk("r_pdone", {31'd0, period_done}, 32'd0);
        chk("r_irq",   {31'd0, irq},         32'd0);
        rst_n = 1'b1;
`else
        // BURST address ignored: continuous operation, irq stays 0
        do_reset();
        wr(3'd5, 16'd1);
        wr(3'd0, 16'd2);
        wr(3'd2, 16'd2);
        wr(3'd4, 16'd1);
        tick();
        for (int p = 0; p < 3; p++) begin
            seg("c_h", 1'b1, 2, 1'b0);
            seg("c_l", 1'b0, 2, 1'b1);
            chk("c_irq", {31'd0, irq}, 32'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
